// File: rtl/alu_pkg.sv
// alu_pkg: alu command codes, default datapath widths and scheduler state encodings.
package alu_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CMD_W = 4;
   typedef enum logic [DEF_CMD_W-1:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESP      = 3'd4
   } state_e;
endpackage

// File: rtl/alu_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick; the search starts just after the last grant.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    any_o
);
   localparam int IW = $clog2(NREQ);
   logic [IW-1:0] j;
   // Walk from farthest to nearest so the closest requester after ptr wins.
   always_comb begin
      j     = '0;
      idx_o = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = IW'((int'(ptr_i) + k) % NREQ);
         if (req_i[j]) idx_o = j;
      end
   end
   assign any_o = |req_i;
   assign gnt_o = any_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one single-issue alu among NREQ requesters with round-robin
// arbitration, sequences the alu handshake per job and bounds each job with a timeout.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CMD_W   = DEF_CMD_W,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*CMD_W-1:0] req_cmd,
   output logic [NREQ-1:0]       req_accept,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_err,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [CMD_W-1:0]      alu_cmd,
   input  logic                  alu_ready,
   input  logic                  alu_valid,
   input  logic [WIDTH-1:0]      alu_result
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CMD_W-1:0] NOP = CMD_W'(OP_NOP);

   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d, id_q, id_d, gnt_idx;
   logic [NREQ-1:0]   acc_q, acc_d, rsp_q, rsp_d, gnt, id_vec;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
   logic              err_q, err_d, any, tmo;
   logic [WIDTH-1:0]  a_arr [NREQ];
   logic [WIDTH-1:0]  b_arr [NREQ];
   logic [CMD_W-1:0]  c_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
      assign c_arr[i] = req_cmd[i*CMD_W +: CMD_W];
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (any)
   );

   assign id_vec  = NREQ'(1) << id_q;
   assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
   assign tmo     = cnt_inc == CW'(TIMEOUT);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      acc_d   = '0;
      rsp_d   = '0;
      res_d   = '0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: if (any) begin
            state_d = S_ISSUE;
            a_d     = a_arr[gnt_idx];
            b_d     = b_arr[gnt_idx];
            cmd_d   = c_arr[gnt_idx];
            id_d    = gnt_idx;
            ptr_d   = gnt_idx;
            acc_d   = gnt;
         end
         S_ISSUE: if (alu_ready) begin
            state_d = S_WAIT_BUSY;
            cmd_d   = NOP;
            cnt_d   = '0;
         end
         S_WAIT_BUSY: begin
            cnt_d = cnt_inc;
            if (!alu_ready) state_d = S_WAIT_DONE;
            else if (tmo) begin
               state_d = S_RESP;
               rsp_d   = id_vec;
               err_d   = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            cnt_d = cnt_inc;
            if (alu_ready && alu_valid) begin
               state_d = S_RESP;
               rsp_d   = id_vec;
               res_d   = alu_result;
            end else if (tmo) begin
               state_d = S_RESP;
               rsp_d   = id_vec;
               err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= IW'(NREQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= NOP;
         cnt_q   <= '0;
         acc_q   <= '0;
         rsp_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rsp_q   <= rsp_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign req_accept = acc_q;
   assign rsp_valid  = rsp_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_cmd    = cmd_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: randomized requesters and a model alu drive the scheduler; a scoreboard
// of predicted responses is checked by an independent monitor.
module tb_alu_scheduler;
   import alu_pkg::*;
   localparam int NREQ = 4, WIDTH = 32, CMD_W = 4, TIMEOUT = 64;

   logic clk = 1'b0, reset_n = 1'b0;
   logic [NREQ-1:0] req_valid = '0, req_accept, rsp_valid;
   logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
   logic [NREQ*CMD_W-1:0] req_cmd = '0;
   logic [WIDTH-1:0] rsp_result, alu_a, alu_b, alu_result = '0;
   logic [CMD_W-1:0] alu_cmd;
   logic rsp_err, alu_ready = 1'b1, alu_valid = 1'b0;

   typedef struct {int id; logic [WIDTH-1:0] res; logic err; int t;} exp_t;
   exp_t sb[$];
   int glog[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, rr_last = NREQ - 1;
   logic [WIDTH-1:0] pa [NREQ], pb [NREQ];
   logic [CMD_W-1:0] pc [NREQ];
   logic [NREQ-1:0] pend = '0, last_vec = '0;
   logic [WIDTH-1:0] last_res = '0, oa, ob;
   logic [CMD_W-1:0] oc;
   logic last_err = 1'b0;
   bit hang = 0, cont = 0;
   int busy_max = 0, busy_fix = -1, phase = 0, busy_n = 0;

   alu_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_cmd(req_cmd), .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_ready(alu_ready),
      .alu_valid(alu_valid), .alu_result(alu_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behaviour of the alu this bench plays; unknown codes give ~a so a wrong cmd is visible.
   function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [CMD_W-1:0] c);
      case (c)
         OP_NOP:  return '0;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return ~a;
      endcase
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH]   = pa[i];
         req_b[i*WIDTH +: WIDTH]   = pb[i];
         req_cmd[i*CMD_W +: CMD_W] = pc[i];
      end
      req_valid = pend;
   endtask

   task automatic new_job(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [CMD_W-1:0] c);
      pa[i] = a;
      pb[i] = b;
      pc[i] = c;
      pend[i] = 1'b1;
      drive_bus();
   endtask

   task automatic rnd_job(input int i);
      new_job(i, $urandom, $urandom, CMD_W'($urandom_range(0, 9)));
   endtask

   // Requester side: checks each accept against "first pending after the last grant".
   initial forever begin
      @(posedge clk); #1;
      if (!reset_n) rr_last = NREQ - 1;
      else if (req_accept != '0) begin
         int id, e;
         logic [NREQ-1:0] prev;
         exp_t x;
         prev = pend;
         id = -1;
         e = -1;
         for (int k = 0; k < NREQ; k++) if (req_accept[k]) id = k;
         for (int k = 1; k <= NREQ; k++) if (e < 0 && prev[(rr_last + k) % NREQ]) e = (rr_last + k) % NREQ;
         chk("accept_onehot", $countones(req_accept), 1);
         chk("grant_order", id, e);
         if (id >= 0) begin
            chk("accept_pending", prev[id], 1);
            chk("issue_a", alu_a, pa[id]);
            chk("issue_b", alu_b, pb[id]);
            chk("issue_cmd", alu_cmd, pc[id]);
            x.id = id;
            x.res = hang ? '0 : alu_fn(pa[id], pb[id], pc[id]);
            x.err = hang;
            x.t = cyc;
            sb.push_back(x);
            pend[id] = 1'b0;
            rr_last = id;
            glog.push_back(id);
            if (cont) rnd_job(id);
            else drive_bus();
         end
      end
   end

   // Model alu: samples on the edge after accept, busy a while, then ready+valid one cycle.
   initial forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
         phase = 0;
         alu_ready = 1'b1;
         alu_valid = 1'b0;
      end else case (phase)
         0: begin
            alu_valid = 1'b0;
            if (req_accept != '0) begin
               oa = alu_a;
               ob = alu_b;
               oc = alu_cmd;
               phase = 1;
            end
         end
         1: begin
            chk("cmd_nop_after_issue", alu_cmd, OP_NOP);
            alu_ready = 1'b0;
            busy_n = busy_fix >= 0 ? busy_fix : $urandom_range(0, busy_max);
            phase = 2;
         end
         2: if (hang) begin
               if (rsp_valid != '0) begin
                  alu_ready = 1'b1;
                  phase = 0;
               end
            end else if (busy_n > 0) busy_n--;
            else begin
               alu_ready = 1'b1;
               alu_valid = 1'b1;
               alu_result = alu_fn(oa, ob, oc);
               phase = 3;
            end
         default: begin
            alu_valid = 1'b0;
            phase = 0;
         end
      endcase
   end

   // Monitor: pops the oldest prediction whenever a response appears.
   initial forever begin
      @(posedge clk); #1;
      if (rsp_valid != '0) begin
         int idx;
         exp_t x;
         idx = -1;
         for (int k = 0; k < NREQ; k++) if (rsp_valid[k]) idx = k;
         last_vec = rsp_valid;
         last_res = rsp_result;
         last_err = rsp_err;
         chk("rsp_onehot", $countones(rsp_valid), 1);
         if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
         else begin
            x = sb.pop_front();
            chk("rsp_id", idx, x.id);
            chk("rsp_result", rsp_result, x.res);
            chk("rsp_err", rsp_err, x.err);
            if (x.err) chk("timeout_latency_in_range", (cyc - x.t >= TIMEOUT) && (cyc - x.t <= TIMEOUT + 8), 1);
         end
      end
   end

   task automatic drain(input int lim);
      int n;
      n = 0;
      while ((pend != '0 || sb.size() != 0 || phase != 0) && n < lim) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= lim) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles, expected 0", sb.size(), lim);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_grants(input int base, input int n, input int lim);
      int k;
      k = 0;
      while (glog.size() < base + n && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk("grant_wait_bound", glog.size() >= base + n, 1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      sb.delete();
      pend = '0;
      drive_bus();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int base;
      for (int i = 0; i < NREQ; i++) begin
         pa[i] = '0;
         pb[i] = '0;
         pc[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_accept", req_accept, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_alu_cmd", alu_cmd, OP_NOP);
      chk("reset_alu_a", alu_a, 0);
      chk("reset_rsp_err", rsp_err, 0);
      reset_n = 1'b1;

      @(negedge clk);
      new_job(1, 5, 7, OP_ADD);
      drain(100);
      chk("t1_rsp_vec", last_vec, 4'b0010);
      chk("t1_result", last_res, 12);
      chk("t1_err", last_err, 0);

      pulse_reset();
      base = glog.size();
      cont = 1;
      for (int i = 0; i < NREQ; i++) rnd_job(i);
      wait_grants(base, 6, 200);
      cont = 0;
      drain(200);
      for (int i = 0; i < 6; i++) if (glog.size() > base + i) chk("fair_order", glog[base + i], i % NREQ);

      @(negedge clk);
      new_job(0, 1, 1, OP_ADD);
      drain(100);
      new_job(0, 9, 4, OP_SUB);
      new_job(2, 9, 4, OP_XOR);
      drain(200);
      chk("t3_first_grant", glog[glog.size() - 2], 2);
      chk("t3_second_grant", glog[glog.size() - 1], 0);

      hang = 1;
      new_job(1, 8, 8, OP_ADD);
      drain(200);
      hang = 0;
      chk("t4_err", last_err, 1);
      chk("t4_result", last_res, 0);
      new_job(2, 1, 2, OP_ADD);
      drain(100);
      chk("t4_next_err", last_err, 0);
      chk("t4_next_result", last_res, 3);

      busy_fix = 20;
      base = glog.size();
      new_job(1, 4, 4, OP_AND);
      wait_grants(base, 1, 50);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_accept", req_accept, 0);
      chk("t5_alu_cmd", alu_cmd, OP_NOP);
      chk("t5_alu_a", alu_a, 0);
      chk("t5_rsp_result", rsp_result, 0);
      sb.delete();
      pend = '0;
      drive_bus();
      @(negedge clk);
      reset_n = 1'b1;
      busy_fix = -1;
      base = glog.size();
      new_job(2, 6, 6, OP_OR);
      new_job(1, 4, 4, OP_AND);
      new_job(0, 2, 3, OP_ADD);
      drain(200);
      if (glog.size() > base) chk("t5_first_grant", glog[base], 0);
      else chk("t5_grant_seen", glog.size(), base + 1);

      new_job(3, 3, 5, OP_SUB);
      drain(100);
      chk("t6_rsp_vec", last_vec, 4'b1000);
      chk("t6_result", last_res, 32'hFFFF_FFFE);
      chk("t6_alu_cmd_idle", alu_cmd, OP_NOP);

      busy_max = 3;
      repeat (400) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 3) == 0) rnd_job(i);
      end
      drain(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
